multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle state machine that sequences the CPU datapath for the 4-bit-opcode ISA.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the shared single-port memory handshake, IR/PC/register-file strobes and a retired-instruction counter.
- Sits between the instruction register and the datapath decoder. It traps to a halt state on a memory timeout.

Parameters:
- MAX_WAIT, 15: maximum extra cycles allowed waiting for mem_ack in FETCH or MEM before trapping. Legal range is 0 or greater.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4  IR[15:12]. Valid and stable from DECODE until the instruction ends.
- Eq  in  1  equality flag from the register compare. Sampled in EXEC.
- mem_ack  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_sel  out  1  address source: 0 = PC (fetch), 1 = ALU/data address.
- ir_load  out  1  load IR from memory read data.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= jump/branch target.
- a_load  out  1  latch register-file operands.
- reg_we  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- bus_err  out  1  sticky; set on memory timeout.
- state  out  3  current state (debug).
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - Reset is asynchronous and active-low. The clock is clk and the reset is rst_n.
  - State, wait counter, bus_err and instr_count are registered.
  - All strobes are combinational from the registered state, opcode, Eq and mem_ack.
- Reset values:
  - state = FETCH (0), wait_cnt = 0, bus_err = 0, instr_count = 0.
  - Because the state is FETCH, mem_req=1 and mem_sel=0 right after reset; every other strobe is 0.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT with bus_err set.
- FETCH:
  - Drives mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack: ir_load=1 and pc_inc=1 in the same cycle, then go to DECODE.
- DECODE: a_load=1 for one cycle, then go to EXEC.
- EXEC, by opcode:
  - 0-6 (ALU ops) and A-D (sl, sr, addi, lui): go to WB.
  - 7 (j): pc_load=1 and instr_done=1, then go to FETCH.
  - 8 (beq): pc_load=Eq and instr_done=1, then go to FETCH.
  - 9 (bne): pc_load=~Eq and instr_done=1, then go to FETCH.
  - E and F (lw, sw): go to MEM.
- MEM:
  - Drives mem_req=1, mem_sel=1, mem_we=(opcode==F).
  - On mem_ack with lw: go to WB.
  - On mem_ack with sw: instr_done=1, then go to FETCH.
- WB: reg_we=1 and instr_done=1, then go to FETCH.
- HALT:
  - All strobes 0 and bus_err=1.
  - Stays in HALT until rst_n is asserted.
- Latency (cycles, with mem_ack in the first cycle of each access):
  - ALU/immediate ops: 4.
  - j, beq, bne: 3.
  - lw: 5.
  - sw: 4.
- Timeout:
  - wait_cnt has width max(1, clog2(MAX_WAIT+1)).
  - It clears on every state transition and on mem_ack.
  - It increments each FETCH/MEM cycle with mem_ack=0.
  - If wait_cnt==MAX_WAIT and mem_ack=0 in FETCH or MEM, the next state is HALT and bus_err is set.
  - An ack arriving on the (MAX_WAIT+1)th cycle is accepted. With MAX_WAIT=0, the ack must arrive in the first cycle.
- mem_ack outside FETCH/MEM is ignored.
- instr_count increments on the clock edge ending any cycle with instr_done=1, wrapping at all-ones to 0.
- Reset mid-operation: a reset in any state, including mid-MEM write, returns immediately to FETCH. No strobes glitch beyond the combinational FETCH outputs.

Test Plan:
- Reset, then add (opcode 4), with mem_ack held 1:
  - State sequence 0,1,2,4,0.
  - reg_we high only in cycle 4.
  - instr_count=1.
- beq (opcode 8) with Eq=1, then with Eq=0:
  - pc_load=1 in EXEC for the first, 0 for the second.
  - Each takes 3 cycles.
  - instr_count=2.
- lw (E) with mem_ack delayed 3 cycles in MEM:
  - mem_sel=1, mem_we=0 for 4 cycles.
  - WB follows.
  - Total 8 cycles.
- sw (F):
  - mem_we=1 in MEM.
  - instr_done on the ack cycle.
  - No WB and no reg_we.
- MAX_WAIT=3 with mem_ack stuck at 0 in FETCH:
  - HALT after 4 FETCH cycles; bus_err=1.
  - Remains in HALT for 20 further cycles.
  - A reset pulse restores FETCH with bus_err=0.
- CNT_W=4, 17 consecutive j instructions: instr_count wraps and reads 1.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 4-bit-opcode CPU: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and traps to HALT when memory stops answering.
module multicycle_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_opcode,
  input  logic             i_eq,
  input  logic             i_mem_ack,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mem_sel,
  output logic             o_ir_load,
  output logic             o_pc_inc,
  output logic             o_pc_load,
  output logic             o_a_load,
  output logic             o_reg_we,
  output logic             o_instr_done,
  output logic             o_bus_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instr_count
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_J   = 4'h7;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_BNE = 4'h9;
  localparam logic [3:0] OP_LW  = 4'hE;
  localparam logic [3:0] OP_SW  = 4'hF;

  logic [2:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_instr_count;

  logic [2:0]        w_next_state;
  logic              w_trap;
  logic              w_wait_expired;
  logic              w_mem_phase;
  logic [WAIT_W-1:0] w_wait_next;

  logic w_mem_req;
  logic w_mem_we;
  logic w_mem_sel;
  logic w_ir_load;
  logic w_pc_inc;
  logic w_pc_load;
  logic w_a_load;
  logic w_reg_we;
  logic w_instr_done;

  assign w_mem_phase    = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);

  // Next-state selection; illegal codes and unanswered accesses both trap.
  always_comb begin
    w_next_state = r_state;
    w_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ack) begin
          w_next_state = S_DECODE;
        end else if (w_wait_expired) begin
          w_next_state = S_HALT;
          w_trap       = 1'b1;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        case (i_opcode)
          OP_J, OP_BEQ, OP_BNE: w_next_state = S_FETCH;
          OP_LW, OP_SW:         w_next_state = S_MEM;
          default:              w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (i_mem_ack) begin
          if (i_opcode == OP_SW) begin
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_wait_expired) begin
          w_next_state = S_HALT;
          w_trap       = 1'b1;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB:   w_next_state = S_FETCH;
      S_HALT: w_next_state = S_HALT;
      default: begin
        w_next_state = S_HALT;
        w_trap       = 1'b1;
      end
    endcase
  end

  // Wait counter only advances while an access is outstanding in the same state.
  always_comb begin
    if ((w_next_state != r_state) || i_mem_ack) begin
      w_wait_next = WAIT_ZERO;
    end else if (w_mem_phase) begin
      w_wait_next = r_wait_cnt + WAIT_ONE;
    end else begin
      w_wait_next = WAIT_ZERO;
    end
  end

  // Datapath strobes decoded from the current state and live inputs.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_sel    = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_a_load     = 1'b0;
    w_reg_we     = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_load = i_mem_ack;
        w_pc_inc  = i_mem_ack;
      end
      S_DECODE: w_a_load = 1'b1;
      S_EXEC: begin
        case (i_opcode)
          OP_J: begin
            w_pc_load    = 1'b1;
            w_instr_done = 1'b1;
          end
          OP_BEQ: begin
            w_pc_load    = i_eq;
            w_instr_done = 1'b1;
          end
          OP_BNE: begin
            w_pc_load    = ~i_eq;
            w_instr_done = 1'b1;
          end
          default: w_instr_done = 1'b0;
        endcase
      end
      S_MEM: begin
        w_mem_req    = 1'b1;
        w_mem_sel    = 1'b1;
        w_mem_we     = (i_opcode == OP_SW);
        w_instr_done = i_mem_ack && (i_opcode == OP_SW);
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_instr_done = 1'b1;
      end
      default: w_mem_req = 1'b0;
    endcase
  end

  // Registered control state, sticky error flag and retire counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= WAIT_ZERO;
      r_bus_err     <= 1'b0;
      r_instr_count <= CNT_ZERO;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      r_bus_err  <= r_bus_err | w_trap;
      if (w_instr_done) begin
        r_instr_count <= r_instr_count + CNT_ONE;
      end else begin
        r_instr_count <= r_instr_count;
      end
    end
  end

  assign o_mem_req     = w_mem_req;
  assign o_mem_we      = w_mem_we;
  assign o_mem_sel     = w_mem_sel;
  assign o_ir_load     = w_ir_load;
  assign o_pc_inc      = w_pc_inc;
  assign o_pc_load     = w_pc_load;
  assign o_a_load      = w_a_load;
  assign o_reg_we      = w_reg_we;
  assign o_instr_done  = w_instr_done;
  assign o_bus_err     = r_bus_err;
  assign o_state       = r_state;
  assign o_instr_count = r_instr_count;

endmodule
